// File: rtl/llr_pair_loader.sv
// Front-end loader for the SC polar decoder: buffers one saturated LLR frame,
// then streams (L[k], L[k+N/2]) pairs to the first f/g stage.
module llr_pair_loader #(
   parameter int bitwidth = 7,
   parameter int in_width = 8,
   parameter int N        = 32
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    flush_i,
   input  logic [in_width-1:0]                     llr_i,
   input  logic                                    llr_valid_i,
   output logic                                    llr_ready_o,
   output logic [bitwidth-1:0]                     r1_o,
   output logic [bitwidth-1:0]                     r2_o,
   output logic [((N/2 > 1) ? $clog2(N/2) : 1)-1:0] pair_idx_o,
   output logic                                    pair_valid_o,
   input  logic                                    pair_ready_i,
   output logic                                    frame_done_o
);

   localparam int AW    = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = (N/2 > 1) ? $clog2(N/2) : 1;
   localparam int M_INT = (1 << (bitwidth - 1)) - 1;

   localparam logic signed [in_width-1:0] SAT_POS  = in_width'(M_INT);
   localparam logic signed [in_width-1:0] SAT_NEG  = -SAT_POS;
   localparam logic [bitwidth-1:0]        OUT_POS  = bitwidth'(M_INT);
   localparam logic [bitwidth-1:0]        OUT_NEG  = bitwidth'(-M_INT);
   localparam logic [AW-1:0]              WR_LAST  = AW'(N - 1);
   localparam logic [PW-1:0]              RD_LAST  = PW'(N/2 - 1);
   localparam logic [AW-1:0]              HALF     = AW'(N/2);

   typedef enum logic [0:0] {
      ST_LOAD  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Symmetric saturation: -(M+1) is folded onto -M so the f/g datapath never sees it.
   function automatic logic [bitwidth-1:0] sat_llr(input logic [in_width-1:0] v);
      logic signed [in_width-1:0] s;
      s = signed'(v);
      if (s > SAT_POS) begin
         return OUT_POS;
      end else if (s < SAT_NEG) begin
         return OUT_NEG;
      end else begin
         return v[bitwidth-1:0];
      end
   endfunction

   state_t              r_state;
   state_t              w_state_n;
   logic [AW-1:0]       r_wr_cnt;
   logic [AW-1:0]       w_wr_cnt_n;
   logic [PW-1:0]       r_rd_cnt;
   logic [PW-1:0]       w_rd_cnt_n;
   logic                r_done;
   logic                w_done_n;
   logic                w_wr_en;
   logic [bitwidth-1:0] w_sat;
   logic [bitwidth-1:0] r_mem [N];
   logic [AW-1:0]       w_a1;
   logic [AW-1:0]       w_a2;
   logic [bitwidth-1:0] w_r1_n;
   logic [bitwidth-1:0] w_r2_n;
   logic [PW-1:0]       w_idx_n;
   logic [bitwidth-1:0] r_r1;
   logic [bitwidth-1:0] r_r2;
   logic [PW-1:0]       r_idx;

   assign w_sat = sat_llr(llr_i);

   // Next-state, counter and completion-pulse logic; flush overrides every accept.
   always_comb begin
      w_state_n  = r_state;
      w_wr_cnt_n = r_wr_cnt;
      w_rd_cnt_n = r_rd_cnt;
      w_done_n   = 1'b0;
      w_wr_en    = 1'b0;
      if (flush_i) begin
         w_state_n  = ST_LOAD;
         w_wr_cnt_n = '0;
         w_rd_cnt_n = '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (llr_valid_i) begin
                  w_wr_en = 1'b1;
                  if (r_wr_cnt == WR_LAST) begin
                     w_wr_cnt_n = '0;
                     w_state_n  = ST_DRAIN;
                  end else begin
                     w_wr_cnt_n = r_wr_cnt + AW'(1);
                  end
               end else begin
                  w_wr_cnt_n = r_wr_cnt;
               end
            end
            ST_DRAIN: begin
               if (pair_ready_i) begin
                  if (r_rd_cnt == RD_LAST) begin
                     w_rd_cnt_n = '0;
                     w_state_n  = ST_LOAD;
                     w_done_n   = 1'b1;
                  end else begin
                     w_rd_cnt_n = r_rd_cnt + PW'(1);
                  end
               end else begin
                  w_rd_cnt_n = r_rd_cnt;
               end
            end
            default: begin
               w_state_n  = ST_LOAD;
               w_wr_cnt_n = '0;
               w_rd_cnt_n = '0;
            end
         endcase
      end
   end

   // Pre-compute the pair shown next cycle; forward the LLR being written so the
   // first pair is correct even when it reads the final entry of the frame.
   always_comb begin
      w_a1    = AW'(w_rd_cnt_n);
      w_a2    = w_a1 + HALF;
      w_r1_n  = '0;
      w_r2_n  = '0;
      w_idx_n = '0;
      if (w_state_n == ST_DRAIN) begin
         w_idx_n = w_rd_cnt_n;
         if (w_wr_en && (r_wr_cnt == w_a1)) begin
            w_r1_n = w_sat;
         end else begin
            w_r1_n = r_mem[w_a1];
         end
         if (w_wr_en && (r_wr_cnt == w_a2)) begin
            w_r2_n = w_sat;
         end else begin
            w_r2_n = r_mem[w_a2];
         end
      end else begin
         w_idx_n = '0;
      end
   end

   // Control state, counters and registered pair outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_LOAD;
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
         r_done   <= 1'b0;
         r_r1     <= '0;
         r_r2     <= '0;
         r_idx    <= '0;
      end else begin
         r_state  <= w_state_n;
         r_wr_cnt <= w_wr_cnt_n;
         r_rd_cnt <= w_rd_cnt_n;
         r_done   <= w_done_n;
         r_r1     <= w_r1_n;
         r_r2     <= w_r2_n;
         r_idx    <= w_idx_n;
      end
   end

   // Frame buffer; survives flush and is simply overwritten by the next frame.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[r_wr_cnt] <= w_sat;
      end else begin
         r_mem[r_wr_cnt] <= r_mem[r_wr_cnt];
      end
   end

   assign llr_ready_o  = (r_state == ST_LOAD);
   assign pair_valid_o = (r_state == ST_DRAIN);
   assign r1_o         = r_r1;
   assign r2_o         = r_r2;
   assign pair_idx_o   = r_idx;
   assign frame_done_o = r_done;

endmodule

// File: tb/tb_llr_pair_loader.sv
// Directed self-checking bench for llr_pair_loader at N=8, bitwidth=7, in_width=8.
module tb_llr_pair_loader;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       flush_i;
   logic [7:0] llr_i;
   logic       llr_valid_i;
   logic       llr_ready_o;
   logic [6:0] r1_o;
   logic [6:0] r2_o;
   logic [1:0] pair_idx_o;
   logic       pair_valid_o;
   logic       pair_ready_i;
   logic       frame_done_o;

   int total = 0;
   int bad   = 0;

   llr_pair_loader #(.bitwidth(7), .in_width(8), .N(8)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .llr_i        (llr_i),
      .llr_valid_i  (llr_valid_i),
      .llr_ready_o  (llr_ready_o),
      .r1_o         (r1_o),
      .r2_o         (r2_o),
      .pair_idx_o   (pair_idx_o),
      .pair_valid_o (pair_valid_o),
      .pair_ready_i (pair_ready_i),
      .frame_done_o (frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load_frame(input int v[8]);
      for (int i = 0; i < 8; i++) begin
         llr_i       = 8'(v[i]);
         llr_valid_i = 1'b1;
         step();
      end
      llr_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; flush_i = 1'b0; llr_i = 8'd0; llr_valid_i = 1'b0; pair_ready_i = 1'b0;
      #12;
      rst_ni = 1'b1;
      step();
      total++;
      if (llr_ready_o !== 1'b1 || pair_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl got rdy=%b vld=%b done=%b want 1 0 0", llr_ready_o, pair_valid_o, frame_done_o);
      end
      total++;
      if (r1_o !== 7'd0 || r2_o !== 7'd0 || pair_idx_o !== 2'd0) begin
         bad++;
         $display("FAIL reset_data got r1=%0d r2=%0d idx=%0d want 0 0 0", r1_o, r2_o, pair_idx_o);
      end
   endtask

   task automatic test_saturation();
      int v[8]  = '{100, -100, -64, 63, 0, 5, -5, 127};
      int e1[4] = '{63, -63, -63, 63};
      int e2[4] = '{0, 5, -5, 63};
      load_frame(v);
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if ($signed(r1_o) !== e1[k] || $signed(r2_o) !== e2[k] || pair_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_pair%0d got r1=%0d r2=%0d vld=%b want %0d %0d 1", k, $signed(r1_o), $signed(r2_o), pair_valid_o, e1[k], e2[k]);
         end
         step();
      end
      pair_ready_i = 1'b0;
      total++;
      if (frame_done_o !== 1'b1) begin
         bad++;
         $display("FAIL sat_done got %b want 1", frame_done_o);
      end
   endtask

   task automatic test_ordering();
      int v[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
      step();
      load_frame(v);
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (r1_o !== 7'(k + 1) || r2_o !== 7'(k + 5) || pair_idx_o !== 2'(k) || frame_done_o !== 1'b0 || llr_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL order_pair%0d got r1=%0d r2=%0d idx=%0d done=%b rdy=%b want %0d %0d %0d 0 0", k, r1_o, r2_o, pair_idx_o, frame_done_o, llr_ready_o, k + 1, k + 5, k);
         end
         step();
      end
      pair_ready_i = 1'b0;
      total++;
      if (frame_done_o !== 1'b1 || llr_ready_o !== 1'b1 || pair_valid_o !== 1'b0 || r1_o !== 7'd0) begin
         bad++;
         $display("FAIL order_done got done=%b rdy=%b vld=%b r1=%0d want 1 1 0 0", frame_done_o, llr_ready_o, pair_valid_o, r1_o);
      end
      step();
      total++;
      if (frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL order_done_pulse got %b want 0", frame_done_o);
      end
   endtask

   task automatic test_backpressure();
      int v[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
      load_frame(v);
      pair_ready_i = 1'b1;
      step();
      pair_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (r1_o !== 7'd2 || r2_o !== 7'd6 || pair_idx_o !== 2'd1 || pair_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold%0d got r1=%0d r2=%0d idx=%0d vld=%b want 2 6 1 1", c, r1_o, r2_o, pair_idx_o, pair_valid_o);
         end
         step();
      end
      pair_ready_i = 1'b1;
      step();
      total++;
      if (r1_o !== 7'd3 || r2_o !== 7'd7 || pair_idx_o !== 2'd2) begin
         bad++;
         $display("FAIL bp_next got r1=%0d r2=%0d idx=%0d want 3 7 2", r1_o, r2_o, pair_idx_o);
      end
      step();
      step();
      pair_ready_i = 1'b0;
      total++;
      if (frame_done_o !== 1'b1) begin
         bad++;
         $display("FAIL bp_done got %b want 1", frame_done_o);
      end
   endtask

   task automatic test_gaps();
      int cnt = 0;
      int cyc = 0;
      while (cnt < 8 && cyc < 100) begin
         llr_valid_i = 1'($urandom_range(0, 1));
         llr_i       = 8'(10 + cnt);
         total++;
         if (llr_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL gap_ready cyc=%0d got %b want 1", cyc, llr_ready_o);
         end
         if (llr_valid_i) cnt++;
         step();
         cyc++;
      end
      total++;
      if (cnt != 8) begin
         bad++;
         $display("FAIL gap_budget got %0d accepts want 8", cnt);
      end
      llr_i = 8'd99;
      llr_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (llr_ready_o !== 1'b0 || pair_valid_o !== 1'b1 || r1_o !== 7'd10 || r2_o !== 7'd14) begin
            bad++;
            $display("FAIL gap_drain%0d got rdy=%b vld=%b r1=%0d r2=%0d want 0 1 10 14", c, llr_ready_o, pair_valid_o, r1_o, r2_o);
         end
         step();
      end
      llr_valid_i = 1'b0;
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (r1_o !== 7'(10 + k) || r2_o !== 7'(14 + k)) begin
            bad++;
            $display("FAIL gap_pair%0d got r1=%0d r2=%0d want %0d %0d", k, r1_o, r2_o, 10 + k, 14 + k);
         end
         step();
      end
      pair_ready_i = 1'b0;
   endtask

   task automatic test_flush();
      int a[8] = '{20, 21, 22, 23, 24, 25, 26, 27};
      int b[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
      for (int i = 0; i < 5; i++) begin
         llr_i = 8'(50 + i); llr_valid_i = 1'b1;
         step();
      end
      llr_i = 8'd99; flush_i = 1'b1;
      step();
      flush_i = 1'b0; llr_valid_i = 1'b0;
      total++;
      if (llr_ready_o !== 1'b1 || pair_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_load got rdy=%b vld=%b done=%b want 1 0 0", llr_ready_o, pair_valid_o, frame_done_o);
      end
      load_frame(a);
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (r1_o !== 7'(20 + k) || r2_o !== 7'(24 + k) || pair_idx_o !== 2'(k)) begin
            bad++;
            $display("FAIL flush_pair%0d got r1=%0d r2=%0d idx=%0d want %0d %0d %0d", k, r1_o, r2_o, pair_idx_o, 20 + k, 24 + k, k);
         end
         step();
      end
      pair_ready_i = 1'b0;
      step();
      load_frame(b);
      pair_ready_i = 1'b1;
      step();
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0; pair_ready_i = 1'b0;
      total++;
      if (pair_valid_o !== 1'b0 || llr_ready_o !== 1'b1 || frame_done_o !== 1'b0 || r1_o !== 7'd0) begin
         bad++;
         $display("FAIL flush_drain got vld=%b rdy=%b done=%b r1=%0d want 0 1 0 0", pair_valid_o, llr_ready_o, frame_done_o, r1_o);
      end
      step();
      total++;
      if (frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_nodone got %b want 0", frame_done_o);
      end
      load_frame(a);
      total++;
      if (r1_o !== 7'd20 || r2_o !== 7'd24 || pair_idx_o !== 2'd0) begin
         bad++;
         $display("FAIL flush_restart got r1=%0d r2=%0d idx=%0d want 20 24 0", r1_o, r2_o, pair_idx_o);
      end
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) step();
      pair_ready_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int v[8] = '{31, 32, 33, 34, 35, 36, 37, 38};
      int b[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
      load_frame(b);
      step();
      rst_ni = 1'b0;
      #2;
      total++;
      if (pair_valid_o !== 1'b0 || llr_ready_o !== 1'b1 || r1_o !== 7'd0 || frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_async got vld=%b rdy=%b r1=%0d done=%b want 0 1 0 0", pair_valid_o, llr_ready_o, r1_o, frame_done_o);
      end
      step();
      rst_ni = 1'b1;
      step();
      total++;
      if (pair_valid_o !== 1'b0 || llr_ready_o !== 1'b1 || frame_done_o !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_release got vld=%b rdy=%b done=%b want 0 1 0", pair_valid_o, llr_ready_o, frame_done_o);
      end
      load_frame(v);
      pair_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (r1_o !== 7'(31 + k) || r2_o !== 7'(35 + k) || pair_idx_o !== 2'(k)) begin
            bad++;
            $display("FAIL rstmid_pair%0d got r1=%0d r2=%0d idx=%0d want %0d %0d %0d", k, r1_o, r2_o, pair_idx_o, 31 + k, 35 + k, k);
         end
         step();
      end
      pair_ready_i = 1'b0;
      total++;
      if (frame_done_o !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_done got %b want 1", frame_done_o);
      end
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_ordering();
      test_backpressure();
      step();
      test_gaps();
      step();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
